// File: rtl/dot_accum_pkg.sv
// Shared types and default widths for the dot-product accumulator.
package dot_accum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

    localparam int DEF_BW  = 16;
    localparam int DEF_LEN = 8;

endpackage

// File: rtl/dot_accum_sat_adder.sv
// Unsigned W-bit adder with carry-out; clamps to all-ones on carry
// when DOT_ACCUM_SAT_EN is defined, otherwise wraps modulo 2^W.
module sat_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = full[W];

`ifdef DOT_ACCUM_SAT_EN
    assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];
`else
    assign sum_o = full[W-1:0];
`endif

endmodule

// File: rtl/dot_accum.sv
// Sums LEN consecutive products into one result on a valid/ready port.
// Optional saturation of the running sum via DOT_ACCUM_SAT_EN (see sat_adder).
//
// state | meaning
// ACC   | accepting products, building the partial sum
// DONE  | result held on res/res_valid until res_ready
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int BW    = DEF_BW,
    parameter int LEN   = DEF_LEN,
    parameter int ACC_W = 2*BW + $clog2(LEN)
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              prod_valid,
    input  logic [2*BW-1:0]   prod,
    output logic              prod_ready,
    input  logic              clr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              res_ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_ovf_q, res_ovf_d;

    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic               accept;

    sat_adder #(.W(ACC_W)) u_add (
        .a_i     (acc_q),
        .b_i     (ACC_W'(prod)),
        .sum_o   (sum),
        .carry_o (carry)
    );

    assign accept = prod_valid && (state_q == ACC);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            ACC: begin
                // clr wins over a product arriving in the same cycle
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        res_d     = sum;
                        res_ovf_d = ovf_q | carry;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = DONE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                        ovf_d = ovf_q | carry;
                    end
                end
            end
            DONE: begin
                if (res_ready) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign prod_ready = (state_q == ACC);
    assign res_valid  = (state_q == DONE);
    assign res        = res_q;
    assign res_ovf    = res_ovf_q;

endmodule

// File: tb/tb_dot_accum.sv
// Self-checking bench for dot_accum (BW=16, LEN=4, ACC_W=32) against a
// queue-based sum model; honours DOT_ACCUM_SAT_EN for expected results.
module tb_dot_accum;

    localparam int BW    = 16;
    localparam int LEN   = 4;
    localparam int ACC_W = 32;

    logic              CLK = 1'b0;
    logic              RESETn = 1'b0;
    logic              prod_valid = 1'b0;
    logic [2*BW-1:0]   prod = '0;
    logic              prod_ready;
    logic              clr = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [ACC_W-1:0]  res;
    logic              res_ovf;

    int checks = 0;
    int errors = 0;
    longint unsigned model_q[$];

    dot_accum #(.BW(BW), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .clr        (clr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .res_ovf    (res_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] p);
        chk("ready_before_feed", {63'd0, prod_ready}, 64'd1);
        prod_valid = 1'b1;
        prod       = p;
        step();
        prod_valid = 1'b0;
        model_q.push_back(longint'(p));
    endtask

    // Expected result: plain sum of the accepted products, then wrap or clamp.
    task automatic check_result(input string tag);
        longint unsigned tot = 0;
        logic [31:0] exp_res;
        logic        exp_ovf;
        foreach (model_q[i]) tot += model_q[i];
        model_q.delete();
        exp_ovf = (tot > 64'h0000_0000_FFFF_FFFF);
`ifdef DOT_ACCUM_SAT_EN
        exp_res = exp_ovf ? 32'hFFFF_FFFF : tot[31:0];
`else
        exp_res = tot[31:0];
`endif
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
        chk({tag, "_res"}, {32'd0, res}, {32'd0, exp_res});
        chk({tag, "_ovf"}, {63'd0, res_ovf}, {63'd0, exp_ovf});
        chk({tag, "_notready"}, {63'd0, prod_ready}, 64'd0);
    endtask

    task automatic take();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("take_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("take_ready_back", {63'd0, prod_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        step();
        step();
        RESETn = 1'b1;
        step();

        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_prod_ready", {63'd0, prod_ready}, 64'd1);
        chk("rst_res", {32'd0, res}, 64'd0);
        chk("rst_res_ovf", {63'd0, res_ovf}, 64'd0);

        // basic sum
        feed(1); feed(2); feed(3); feed(4);
        chk("basic_const", {32'd0, res}, 64'd10);
        check_result("basic");

        // backpressure: offered product must be dropped
        prod_valid = 1'b1;
        prod       = 32'd100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {63'd0, res_valid}, 64'd1);
            chk("bp_res", {32'd0, res}, 64'd10);
            chk("bp_notready", {63'd0, prod_ready}, 64'd0);
        end
        prod_valid = 1'b0;
        take();
        feed(5); feed(5); feed(5); feed(5);
        chk("bp_next_const", {32'd0, res}, 64'd20);
        check_result("bp_next");
        take();

        // gaps then clr
        feed(7);
        step();
        feed(9);
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_q.delete();
        feed(1); feed(1); feed(1); feed(1);
        chk("clr_const", {32'd0, res}, 64'd4);
        check_result("clr");
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_done_valid", {63'd0, res_valid}, 64'd1);
        chk("clr_done_res", {32'd0, res}, 64'd4);
        take();

        // clr together with a product: product discarded
        feed(3);
        clr = 1'b1; prod_valid = 1'b1; prod = 32'd50;
        step();
        clr = 1'b0; prod_valid = 1'b0;
        model_q.delete();
        feed(1); feed(1); feed(1); feed(1);
        chk("clr_same_const", {32'd0, res}, 64'd4);
        check_result("clr_same");
        take();

        // overflow
        for (int i = 0; i < 4; i++) feed(32'hFFFE_0001);
`ifdef DOT_ACCUM_SAT_EN
        chk("ovf_const", {32'd0, res}, 64'h0000_0000_FFFF_FFFF);
`else
        chk("ovf_const", {32'd0, res}, 64'h0000_0000_FFF8_0004);
`endif
        chk("ovf_flag_const", {63'd0, res_ovf}, 64'd1);
        check_result("ovf");
        take();
        feed(1); feed(2); feed(3); feed(4);
        check_result("ovf_after");
        take();

        // async reset mid-accumulation
        feed(2); feed(2);
        RESETn = 1'b0;
        #2;
        chk("arst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("arst_res", {32'd0, res}, 64'd0);
        chk("arst_res_ovf", {63'd0, res_ovf}, 64'd0);
        chk("arst_prod_ready", {63'd0, prod_ready}, 64'd1);
        model_q.delete();
        step();
        RESETn = 1'b1;
        step();
        feed(2); feed(2); feed(2); feed(2);
        chk("arst_after_const", {32'd0, res}, 64'd8);
        check_result("arst_after");
        take();

        // randomized results with gaps and backpressure
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < LEN; k++) begin
                longint unsigned a, b;
                int gaps;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    prod = $urandom();
                    step();
                end
                if ($urandom_range(0, 3) == 0) begin
                    a = $urandom_range(0, 255);
                    b = $urandom_range(0, 255);
                end else begin
                    a = $urandom_range(0, 65535);
                    b = $urandom_range(0, 65535);
                end
                feed(32'(a * b));
            end
            check_result("rand");
            held = res;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                prod_valid = 1'($urandom_range(0, 1));
                prod       = $urandom();
                step();
                chk("rand_hold_valid", {63'd0, res_valid}, 64'd1);
                chk("rand_hold_res", {32'd0, res}, {32'd0, held});
            end
            prod_valid = 1'b0;
            take();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_accum.md
# dot_accum

Downstream consumer of the multiplier stage: accepts a stream of 2·BW-bit unsigned products, sums LEN consecutive products into one dot-product result, and presents that result on a valid/ready output port. The block sits between the multiplier's registered `out` and the result bus of the datapath. It owns the product-count state machine and backpressure toward the operand issuer.

## Interface

**Parameters**
- `BW`, default 16: multiplier operand width; the product width is 2·BW.
- `LEN`, default 8: number of products per result; must be ≥ 1.
- `ACC_W`, default 2·BW+$clog2(LEN): accumulator and result width; must be ≥ 2·BW.

**Ports**
- `CLK`, in, 1: clock, rising-edge.
- `RESETn`, in, 1: asynchronous active-low reset.
- `prod_valid`, in, 1: `prod` holds a product this cycle.
- `prod`, in, 2·BW: unsigned product from the multiplier.
- `prod_ready`, out, 1: the block accepts a product this cycle.
- `clr`, in, 1: synchronous abort of the partial sum.
- `res_valid`, out, 1: `res` is valid.
- `res_ready`, in, 1: the consumer takes `res`.
- `res`, out, ACC_W: dot-product result.
- `res_ovf`, out, 1: an overflow occurred during this result's accumulation.

## Operation

- **Reset values:** every output resets to 0, except `prod_ready`. Internally, `state`=ACC, `cnt`=0, `acc`=0, `res`=0, `res_ovf`=0, and `prod_ready`=1 after reset.
- **Accept rule:** a product is accepted when `prod_valid && prod_ready`. `prod_ready` = (`state`==ACC). The issuer must stop multiplier issue while `prod_ready`=0; a product presented while not ready is dropped.
- **ACC state:** on accept, `acc` ← `acc` + zero-extended `prod`, and `cnt` ← `cnt`+1.
  - On the accept with `cnt`==LEN-1: `res` ← `acc`+`prod`, `res_ovf` ← sticky overflow of the final add, `acc` ← 0, `cnt` ← 0, and `state` → DONE.
- **DONE state:** `res_valid`=1, and `res`/`res_ovf` hold stable. When `res_ready`=1 the state returns to ACC next cycle and `res_valid` drops. No product is accepted in DONE.
- **`clr` in ACC:** `acc` ← 0, `cnt` ← 0, and the sticky overflow is cleared. A product accepted in the same cycle is discarded.
- **`clr` in DONE:** ignored. A result is never destroyed once valid.
- **Overflow:** carry-out of the ACC_W-bit add sets the sticky bit. Wrap or saturate behaviour is chosen by the configuration macro below.
- **Count wrap:** `cnt` is $clog2(LEN)-bit, or 1 bit when LEN=1, and never exceeds LEN-1.
- **Asynchronous reset mid-operation:** the partial sum and any pending result are lost, and all state returns to reset values immediately.

## Timing

- `res_valid` rises on the cycle after the LEN-th accepted product.
- Minimum throughput is LEN+1 cycles per result, with one bubble in DONE when `res_ready` is held high.
- `prod_valid` gaps are allowed; they do not change `cnt`.
- `prod_ready` is a registered-state decode with no combinational path from `res_ready`.
- `res` changes only on the cycle entering DONE.

## Configuration

- **`DOT_ACCUM_SAT_EN` defined:** on overflow, `acc` and `res` clamp to 2^ACC_W−1 and stay clamped until the result is taken or cleared. `res_ovf` is still reported.
- **`DOT_ACCUM_SAT_EN` undefined:** the sum wraps modulo 2^ACC_W, and `res_ovf` reports that a wrap occurred.

## Structure

- **Shared package `dot_accum_pkg`:** state enum {ACC, DONE} and the default-width constants (BW=16, LEN=8).
- **Sub-module `sat_adder`:** ACC_W-bit adder with carry-out and optional clamp, gated by `DOT_ACCUM_SAT_EN`. The FSM, counter and output registers live in `dot_accum`.

## Test plan

All scenarios use BW=16, LEN=4 unless stated.

- **Basic sum:** products 1,2,3,4 accepted back-to-back → `res`=10, `res_valid` one cycle after the 4th, `res_ovf`=0.
- **Backpressure:** `res_ready`=0 for 5 cycles after DONE → `res`=10 held, `prod_ready`=0 throughout, and the product offered meanwhile is not counted. The next result (5,5,5,5) gives `res`=20.
- **Gaps and clr:** products 7,_,9 then `clr`, then 1,1,1,1 → `res`=4. A `clr` issued in DONE leaves `res` unchanged.
- **Overflow wrap:** ACC_W=32, macro off, four products of 0xFFFE0001 → `res`=0xFFF80004, `res_ovf`=1.
- **Overflow saturate:** same stimulus with `DOT_ACCUM_SAT_EN` defined → `res`=0xFFFFFFFF, `res_ovf`=1.
- **Reset mid-op:** assert RESETn=0 after two products → all outputs 0 at once. After release, 2,2,2,2 gives `res`=8.
